// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types, sizes and scan-length helper for the mux scan controller
//
// Purpose: common definitions used by mux_scan_ctrl and its sub-module.
//   WIDTH / SEL_WIDTH : mux data width and select width (WIDTH == 2**SEL_WIDTH)
//   scan_state_t      : controller FSM states
//   scan_len()        : number of bits a first..last scan covers, wrapping mod WIDTH
package mux_scan_pkg;

  localparam int WIDTH     = 16;
  localparam int SEL_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  // The SEL_WIDTH-bit subtraction wraps naturally, so last < first gives the wrapped length.
  function automatic logic [SEL_WIDTH:0] scan_len(input logic [SEL_WIDTH-1:0] first,
                                                  input logic [SEL_WIDTH-1:0] last);
    logic [SEL_WIDTH-1:0] w_diff;
    w_diff = last - first;
    return {1'b0, w_diff} + (SEL_WIDTH+1)'(1);
  endfunction

endpackage

// File: rtl/mux_16x1.sv
// rtl/mux_16x1.sv - combinational 16-to-1 bit multiplexer
//
// Ports:
//   i_data_in  : WIDTH-bit data word
//   i_select   : SEL_WIDTH-bit index
//   o_data_out : i_data_in[i_select]
module mux_16x1 #(
  parameter int WIDTH     = mux_scan_pkg::WIDTH,
  parameter int SEL_WIDTH = mux_scan_pkg::SEL_WIDTH
) (
  input  logic [WIDTH-1:0]     i_data_in,
  input  logic [SEL_WIDTH-1:0] i_select,
  output logic                 o_data_out
);

  assign o_data_out = i_data_in[i_select];

endmodule

// File: rtl/sel_wrap_counter.sv
// rtl/sel_wrap_counter.sv - loadable modulo-2**SEL_WIDTH select counter with terminal match
//
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : load i_first into the counter and latch i_last as terminal value
//   i_first      : start index
//   i_last       : terminal index
//   i_en         : advance by one, wrapping from all-ones to zero
//   o_value      : current count (drives the mux select)
//   o_match      : current count equals the latched terminal index
module sel_wrap_counter #(
  parameter int SEL_WIDTH = mux_scan_pkg::SEL_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic [SEL_WIDTH-1:0] i_first,
  input  logic [SEL_WIDTH-1:0] i_last,
  input  logic                 i_en,
  output logic [SEL_WIDTH-1:0] o_value,
  output logic                 o_match
);

  logic [SEL_WIDTH-1:0] r_value;
  logic [SEL_WIDTH-1:0] r_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_value <= '0;
      r_last  <= '0;
    end else if (i_load) begin
      r_value <= i_first;
      r_last  <= i_last;
    end else if (i_en) begin
      // Width is exactly SEL_WIDTH, so overflow is the mod-WIDTH wrap.
      r_value <= r_value + SEL_WIDTH'(1);
    end
  end

  assign o_value = r_value;
  assign o_match = (r_value == r_last);

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - scans a mux select range and reassembles the sampled bits into a word
//
// Ports:
//   i_clk, i_rst              : clock, synchronous active-high reset
//   i_start                   : scan request (taken in IDLE, or in DONE together with the handshake)
//   i_first_sel, i_last_sel   : scan range, latched on accept; last below first wraps
//   o_select                  : mux select
//   i_mux_bit                 : mux data_out, sampled at the end of each SCAN cycle
//   o_busy                    : high in SCAN and DONE
//   o_out_valid, i_out_ready  : result handshake
//   o_out_word                : assembled word, bit i = sample taken with select == i
//   o_out_count               : number of bits scanned
module mux_scan_ctrl #(
  parameter int WIDTH     = mux_scan_pkg::WIDTH,
  parameter int SEL_WIDTH = mux_scan_pkg::SEL_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [SEL_WIDTH-1:0] i_first_sel,
  input  logic [SEL_WIDTH-1:0] i_last_sel,
  output logic [SEL_WIDTH-1:0] o_select,
  input  logic                 i_mux_bit,
  output logic                 o_busy,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [WIDTH-1:0]     o_out_word,
  output logic [SEL_WIDTH:0]   o_out_count
);

  import mux_scan_pkg::*;

  scan_state_t          r_state;
  scan_state_t          w_state_nxt;
  logic                 w_accept;
  logic                 w_cnt_en;
  logic                 w_match;
  logic [SEL_WIDTH-1:0] w_select;
  logic [WIDTH-1:0]     r_word;
  logic [SEL_WIDTH:0]   r_count;

  sel_wrap_counter #(
    .SEL_WIDTH(SEL_WIDTH)
  ) u_sel_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_accept),
    .i_first (i_first_sel),
    .i_last  (i_last_sel),
    .i_en    (w_cnt_en),
    .o_value (w_select),
    .o_match (w_match)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // The select holds on the terminal sample so it is stable for all of DONE.
        if (w_match) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        // A start is only honoured when the pending result is taken in the same cycle.
        if (i_out_ready) begin
          if (i_start) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_SCAN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Word/count are only cleared on a new accept, so they stay readable in IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word  <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_word  <= '0;
      r_count <= '0;
    end else if (r_state == ST_SCAN) begin
      r_word[w_select] <= i_mux_bit;
      r_count          <= r_count + (SEL_WIDTH+1)'(1);
    end
  end

  assign o_select    = w_select;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_out_valid = (r_state == ST_DONE);
  assign o_out_word  = r_word;
  assign o_out_count = r_count;

endmodule
